// File: rtl/stopwatch_ctrl.sv
// SS.CC stopwatch sequencer: synchronizes the 100 Hz divider output, counts BCD centiseconds, runs IDLE/RUN/LAP/PAUSE/DONE.
// Count moves 3 clk_in edges after a sampled 100 Hz rising edge; one-cycle button pulses, no backpressure.
module stopwatch_ctrl #(
  parameter int SEC_MAX     = 59,
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk_in,
  input  logic       rst,
  input  logic       clk_100hz,
  input  logic       btn_start_stop,
  input  logic       btn_lap,
  input  logic       btn_clear,
  output logic [3:0] sec_tens,
  output logic [3:0] sec_ones,
  output logic [3:0] csec_tens,
  output logic [3:0] csec_ones,
  output logic       running,
  output logic       lap_active,
  output logic       overflow
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RUN   = 3'd1,
    ST_LAP   = 3'd2,
    ST_PAUSE = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  typedef struct packed {
    logic [3:0] st;
    logic [3:0] so;
    logic [3:0] ct;
    logic [3:0] co;
  } bcd_t;

  localparam bcd_t CNT_MAX = '{st: 4'(SEC_MAX / 10), so: 4'(SEC_MAX % 10), ct: 4'd9, co: 4'd9};

  function automatic bcd_t bcd_inc(input bcd_t v);
    bcd_t r;
    r = v;
    if (v.co != 4'd9) begin
      r.co = v.co + 4'd1;
    end else begin
      r.co = 4'd0;
      if (v.ct != 4'd9) begin
        r.ct = v.ct + 4'd1;
      end else begin
        r.ct = 4'd0;
        if (v.so != 4'd9) begin
          r.so = v.so + 4'd1;
        end else begin
          r.so = 4'd0;
          r.st = v.st + 4'd1;
        end
      end
    end
    return r;
  endfunction

  state_t                 state_q, state_d;
  bcd_t                   cnt_q, cnt_d;
  bcd_t                   lap_q, lap_d;
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [SYNC_STAGES-1:0] sync_vld_q, sync_vld_d;
  logic                   sync_prev_q, sync_prev_d;
  logic                   armed_q, armed_d;
  logic                   tick_q, tick_d;
  logic                   running_q, running_d;
  logic                   lap_active_q, lap_active_d;
  logic                   overflow_q, overflow_d;

  logic synced;
  logic counting;
  logic at_max;
  logic clear_act, start_act, lap_act;
  bcd_t disp;

  // Edge detection; armed only once the chain has seen a genuine low after reset,
  // so a level already high at reset release never produces a tick.
  always_comb begin
    sync_d      = {sync_q[SYNC_STAGES-2:0], clk_100hz};
    sync_vld_d  = {sync_vld_q[SYNC_STAGES-2:0], 1'b1};
    synced      = sync_q[SYNC_STAGES-1];
    sync_prev_d = synced;
    armed_d     = armed_q | (sync_vld_q[SYNC_STAGES-1] & ~synced);
    tick_d      = armed_q & synced & ~sync_prev_q;
  end

  always_comb begin
    clear_act = btn_clear;
    start_act = btn_start_stop & ~btn_clear;
    lap_act   = btn_lap & ~btn_clear & ~btn_start_stop;
    counting  = (state_q == ST_RUN) || (state_q == ST_LAP);
    at_max    = (cnt_q == CNT_MAX);

    cnt_d = cnt_q;
    if (tick_q && counting && !at_max) begin
      cnt_d = bcd_inc(cnt_q);
    end

    state_d = state_q;
    lap_d   = lap_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start_act) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (start_act) begin
          state_d = ST_PAUSE;
        end else if (lap_act) begin
          state_d = ST_LAP;
          lap_d   = cnt_d;
        end
      end
      ST_LAP: begin
        if (start_act) state_d = ST_PAUSE;
        else if (lap_act) state_d = ST_RUN;
      end
      ST_PAUSE: begin
        if (clear_act) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else if (start_act) begin
          state_d = ST_RUN;
        end
      end
      ST_DONE: begin
        if (clear_act) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Saturation outranks any button acting in the same cycle.
    if (tick_q && counting && at_max) begin
      state_d = ST_DONE;
    end

    running_d    = (state_d == ST_RUN) || (state_d == ST_LAP);
    lap_active_d = (state_d == ST_LAP);
    overflow_d   = (state_d == ST_DONE);
  end

  always_ff @(posedge clk_in or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      lap_q        <= '0;
      sync_q       <= '0;
      sync_vld_q   <= '0;
      sync_prev_q  <= 1'b0;
      armed_q      <= 1'b0;
      tick_q       <= 1'b0;
      running_q    <= 1'b0;
      lap_active_q <= 1'b0;
      overflow_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      lap_q        <= lap_d;
      sync_q       <= sync_d;
      sync_vld_q   <= sync_vld_d;
      sync_prev_q  <= sync_prev_d;
      armed_q      <= armed_d;
      tick_q       <= tick_d;
      running_q    <= running_d;
      lap_active_q <= lap_active_d;
      overflow_q   <= overflow_d;
    end
  end

  always_comb begin
    disp = lap_active_q ? lap_q : cnt_q;
  end

  assign sec_tens   = disp.st;
  assign sec_ones   = disp.so;
  assign csec_tens  = disp.ct;
  assign csec_ones  = disp.co;
  assign running    = running_q;
  assign lap_active = lap_active_q;
  assign overflow   = overflow_q;

  a_cnt_bcd: assert property (@(posedge clk_in) disable iff (!rst)
    (cnt_q.co <= 4'd9) && (cnt_q.ct <= 4'd9) && (cnt_q.so <= 4'd9) && (cnt_q.st <= 4'd9));

endmodule

// File: doc/stopwatch_ctrl.md
Name: stopwatch_ctrl

Overview:
Controller that sequences the 100 Hz timebase from the frequency divider into a start/stop/lap/clear stopwatch, counting SS.CC (seconds 00-59, centiseconds 00-99).
It sits between the divider and the seven-segment scan logic. It consumes the divider's 100 Hz square wave plus one-cycle button pulses, and drives four BCD digits and status flags.
All logic runs on clk_in; the 100 Hz input is treated as data, never as a clock.

Parameters:
SEC_MAX, 59, highest seconds value; count saturates at SEC_MAX.99
SYNC_STAGES, 2, flip-flop stages synchronizing clk_100hz before edge detection (minimum 2)

Ports:
clk_in  input  1  system clock
rst  input  1  asynchronous, active-low reset
clk_100hz  input  1  100 Hz square wave from the divider; each rising edge is one centisecond tick
btn_start_stop  input  1  one-cycle pulse (debounced upstream): toggles run/pause
btn_lap  input  1  one-cycle pulse: freeze/release the displayed value
btn_clear  input  1  one-cycle pulse: zero the count when stopped
sec_tens  output  4  displayed seconds tens digit, BCD
sec_ones  output  4  displayed seconds ones digit, BCD
csec_tens  output  4  displayed centiseconds tens digit, BCD
csec_ones  output  4  displayed centiseconds ones digit, BCD
running  output  1  high in RUN or LAP
lap_active  output  1  high in LAP (display frozen)
overflow  output  1  high in DONE

Behaviour:
- Reset (rst low, asynchronous): state IDLE; count, lap latch and sync chain cleared; all digits 0; running, lap_active and overflow 0.
- Tick generation:
  - clk_100hz passes through SYNC_STAGES flops.
  - tick = synced & ~synced_d, a one-cycle pulse.
  - With SYNC_STAGES=2, a rising edge sampled at edge N gives tick high during cycle N+2; the count changes at edge N+3.
- Count: four BCD registers with ripple carry.
  - csec_ones 9->0 carries into csec_tens; csec_tens 9->0 carries into sec_ones; sec_ones 9->0 carries into sec_tens.
  - The count never holds a non-BCD value.
- Count increments on a tick only in RUN or LAP, and only when count != SEC_MAX.99.
- Display:
  - In LAP, the digits show the lap latch.
  - In every other state, the digits show the live count.
  - Outputs are driven directly from registers through a mux; no added latency.
- Button priority: clear > start_stop > lap. At most one button acts per cycle; lower-priority pulses in the same cycle are dropped.
- States and transitions:
  - IDLE: start_stop -> RUN. lap and clear ignored.
  - RUN:
    - start_stop -> PAUSE.
    - lap -> LAP; the lap latch captures the count value after this cycle's tick.
    - clear ignored.
    - Tick with count == SEC_MAX.99 -> DONE.
  - LAP: count keeps running behind the frozen display.
    - lap -> RUN (display live).
    - start_stop -> PAUSE; the lap is released and the display goes live.
    - clear ignored.
    - Tick at SEC_MAX.99 -> DONE.
  - PAUSE: start_stop -> RUN; clear -> IDLE with count zeroed; lap ignored.
  - DONE:
    - Count holds SEC_MAX.99; overflow=1; display live.
    - clear -> IDLE with count zeroed.
    - start_stop, lap and ticks ignored.
- Same-cycle tick and button: the increment is decided by the current state, and the transition by the button. Example: RUN + tick + start_stop -> count increments, next state PAUSE.
- Same-cycle saturation: tick at SEC_MAX.99 together with start_stop in RUN -> DONE wins over PAUSE.
- Reset mid-operation: immediate return to the reset values, independent of clk_in. The first tick after rst deasserts needs a fresh rising edge on clk_100hz; a level that was already high does not count.

Test Plan:
- Reset, pulse start_stop, apply 100 clk_100hz rising edges -> digits 0,1,0,0 (01.00); running=1; overflow=0.
- Reach 09.99 in RUN, one more rising edge -> 10.00 exactly 3 clk_in cycles after the sampled edge; no intermediate non-BCD value.
- At 03.25 pulse btn_lap, then 50 ticks -> digits stay 03.25 with lap_active=1; pulse btn_lap -> digits 03.75, lap_active=0.
- Run to 59.99, one tick -> DONE, overflow=1, running=0; 10 more ticks -> still 59.99; btn_clear -> 00.00, state IDLE, overflow=0.
- In PAUSE at 12.34, pulse btn_clear and btn_start_stop together -> 00.00 IDLE, not running. In RUN, tick coincident with btn_start_stop at 00.07 -> 00.08 and PAUSE.
- In RUN at 05.00, assert rst low between clk_in edges -> outputs all 0 with no clock edge. With clk_100hz held high through release -> no tick until its next rising edge.
